// File: rtl/miss_repair_controller_pkg.sv
// Shared constants and state encoding for the cache miss-repair path.
package miss_repair_controller_pkg;

  localparam int DCACHE_LINE_WORDS = 4;
  localparam int ROB_ENTRIES       = 32;

  typedef enum logic [2:0] {
    IDLE,
    MREQ,
    WAIT,
    RESP,
    DONE
  } repair_state_t;

endpackage

// File: rtl/miss_repair_controller.sv
// Fetches a missing cache line, streams it into the L1 fill port with store
// data merged in, and returns the missed word for loads.
module miss_repair_controller
  import miss_repair_controller_pkg::*;
#(
  parameter int LINE_WORDS = DCACHE_LINE_WORDS,
  parameter int ROB_IDX_W  = $clog2(ROB_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 repair_req_i,
  input  logic [31:0]          repair_req_addr_i,
  input  logic [31:0]          repair_req_data_i,
  input  logic [ROB_IDX_W-1:0] repair_req_rob_idx_i,
  input  logic                 repair_is_store_i,
  output logic                 repair_ack_o,
  output logic                 repair_complete_o,
  output logic                 mem_req_o,
  output logic [31:0]          mem_req_addr_o,
  input  logic                 mem_req_ready_i,
  input  logic                 mem_rsp_valid_i,
  input  logic [31:0]          mem_rsp_data_i,
  output logic                 fill_en_o,
  output logic [31:0]          fill_addr_o,
  output logic [31:0]          fill_data_o,
  output logic                 fill_last_o,
  output logic                 ld_rsp_valid_o,
  output logic [31:0]          ld_rsp_data_o,
  output logic [ROB_IDX_W-1:0] ld_rsp_rob_idx_o
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int LINE_LSB = OFF_W + 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  repair_state_t        state;
  logic [31:2]          req_waddr;
  logic [31:0]          req_data;
  logic [ROB_IDX_W-1:0] req_rob_idx;
  logic                 req_is_store;
  logic                 drop;
  logic [OFF_W-1:0]     beat_cnt;
  logic [31:0]          ld_data;

  logic [31:0]      line_base;
  logic [OFF_W-1:0] word_off;
  logic             hit_word;
  logic             last_beat;

  assign line_base = {req_waddr[31:LINE_LSB], {LINE_LSB{1'b0}}};
  assign word_off  = req_waddr[LINE_LSB-1:2];
  assign hit_word  = (beat_cnt == word_off);
  assign last_beat = (beat_cnt == LAST_BEAT);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_waddr    <= '0;
      req_data     <= '0;
      req_rob_idx  <= '0;
      req_is_store <= 1'b0;
      drop         <= 1'b0;
      beat_cnt     <= '0;
      ld_data      <= '0;
    end else begin
      // A flush only cancels the pending load result; the fill still finishes.
      if (flush_i && !req_is_store && (state inside {MREQ, WAIT, RESP}))
        drop <= 1'b1;

      case (state)
        IDLE: begin
          if (repair_req_i) begin
            req_waddr    <= repair_req_addr_i[31:2];
            req_data     <= repair_req_data_i;
            req_rob_idx  <= repair_req_rob_idx_i;
            req_is_store <= repair_is_store_i;
            beat_cnt     <= '0;
            drop         <= 1'b0;
            state        <= MREQ;
          end
        end
        MREQ: if (mem_req_ready_i) state <= WAIT;
        WAIT: begin
          if (mem_rsp_valid_i) begin
            if (!req_is_store && hit_word) ld_data <= mem_rsp_data_i;
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= req_is_store ? DONE : RESP;
          end
        end
        RESP:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    repair_ack_o      = 1'b0;
    repair_complete_o = 1'b0;
    mem_req_o         = 1'b0;
    mem_req_addr_o    = '0;
    fill_en_o         = 1'b0;
    fill_addr_o       = '0;
    fill_data_o       = '0;
    fill_last_o       = 1'b0;
    ld_rsp_valid_o    = 1'b0;
    ld_rsp_data_o     = '0;
    ld_rsp_rob_idx_o  = '0;
    case (state)
      IDLE: repair_ack_o = repair_req_i && !rst_i;
      MREQ: begin
        mem_req_o      = 1'b1;
        mem_req_addr_o = line_base;
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          fill_en_o   = 1'b1;
          fill_addr_o = line_base + (32'(beat_cnt) << 2);
          fill_data_o = (req_is_store && hit_word) ? req_data : mem_rsp_data_i;
          fill_last_o = last_beat;
        end
      end
      RESP: begin
        ld_rsp_valid_o = !drop && !flush_i;
        if (ld_rsp_valid_o) begin
          ld_rsp_data_o    = ld_data;
          ld_rsp_rob_idx_o = req_rob_idx;
        end
      end
      DONE:    repair_complete_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_miss_repair_controller.sv
// Directed and randomized checks of miss_repair_controller against a
// line-level reference model with a reactive memory responder.
module tb_miss_repair_controller;

  localparam int LW    = 4;
  localparam int ROB_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             repair_req_i;
  logic [31:0]      repair_req_addr_i;
  logic [31:0]      repair_req_data_i;
  logic [ROB_W-1:0] repair_req_rob_idx_i;
  logic             repair_is_store_i;
  logic             repair_ack_o;
  logic             repair_complete_o;
  logic             mem_req_o;
  logic [31:0]      mem_req_addr_o;
  logic             mem_req_ready_i;
  logic             mem_rsp_valid_i;
  logic [31:0]      mem_rsp_data_i;
  logic             fill_en_o;
  logic [31:0]      fill_addr_o;
  logic [31:0]      fill_data_o;
  logic             fill_last_o;
  logic             ld_rsp_valid_o;
  logic [31:0]      ld_rsp_data_o;
  logic [ROB_W-1:0] ld_rsp_rob_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_line [LW];

  miss_repair_controller #(.LINE_WORDS(LW), .ROB_IDX_W(ROB_W)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .flush_i              (flush_i),
    .repair_req_i         (repair_req_i),
    .repair_req_addr_i    (repair_req_addr_i),
    .repair_req_data_i    (repair_req_data_i),
    .repair_req_rob_idx_i (repair_req_rob_idx_i),
    .repair_is_store_i    (repair_is_store_i),
    .repair_ack_o         (repair_ack_o),
    .repair_complete_o    (repair_complete_o),
    .mem_req_o            (mem_req_o),
    .mem_req_addr_o       (mem_req_addr_o),
    .mem_req_ready_i      (mem_req_ready_i),
    .mem_rsp_valid_i      (mem_rsp_valid_i),
    .mem_rsp_data_i       (mem_rsp_data_i),
    .fill_en_o            (fill_en_o),
    .fill_addr_o          (fill_addr_o),
    .fill_data_o          (fill_data_o),
    .fill_last_o          (fill_last_o),
    .ld_rsp_valid_o       (ld_rsp_valid_o),
    .ld_rsp_data_o        (ld_rsp_data_o),
    .ld_rsp_rob_idx_o     (ld_rsp_rob_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {58'd0, repair_ack_o, repair_complete_o, mem_req_o,
                           fill_en_o, fill_last_o, ld_rsp_valid_o}, 64'd0);
    check({tag, "_mem_addr"}, {32'd0, mem_req_addr_o}, 64'd0);
    check({tag, "_fill_bus"}, {fill_addr_o, fill_data_o}, 64'd0);
    check({tag, "_ld_bus"}, {27'd0, ld_rsp_data_o, ld_rsp_rob_idx_o}, 64'd0);
  endtask

  // One repair from ack to complete, with a memory that answers mem_req_o
  // after ready_dly cycles and spaces beats by gap idle cycles.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [ROB_W-1:0] rob, input logic is_store,
                         input int ready_dly, input int gap, input int flush_beat,
                         input logic hold_req, input logic check_lat);
    logic [31:0] base;
    int          off;
    int          cyc = 0;
    int          req_wait = 0;
    int          beats_sent = 0;
    int          gap_cnt = 0;
    int          acks = 0, completes = 0, lds = 0;
    int          ack_cyc = -1, comp_cyc = -1, ld_cyc = -1;
    bit          accepted = 0, accept_now, flushed = 0, drv_valid, done = 0;
    logic [31:0] f_addr [$];
    logic [31:0] f_data [$];
    logic        f_last [$];
    logic [31:0] exp_word;

    base = addr & ~32'(LW * 4 - 1);
    off  = int'((addr % (LW * 4)) / 4);

    while (!done) begin
      @(negedge clk_i);
      repair_req_i         = hold_req || (acks == 0);
      repair_req_addr_i    = addr;
      repair_req_data_i    = sdata;
      repair_req_rob_idx_i = rob;
      repair_is_store_i    = is_store;
      flush_i              = 1'b0;
      drv_valid            = 1'b0;
      mem_rsp_valid_i      = 1'b0;
      mem_rsp_data_i       = $urandom;
      if (accepted && beats_sent < LW) begin
        if (flush_beat == beats_sent && !flushed) begin
          flush_i = 1'b1;
          flushed = 1;
        end
        if (gap_cnt == 0) begin
          drv_valid       = 1'b1;
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i  = mem_line[beats_sent];
          beats_sent++;
          gap_cnt = gap;
        end else begin
          gap_cnt--;
        end
      end
      #1;
      accept_now      = mem_req_o && (req_wait >= ready_dly);
      mem_req_ready_i = accept_now || (!mem_req_o && $urandom_range(1) == 1);
      if (mem_req_o) req_wait++;
      #1;
      if (repair_ack_o) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = cyc;
      end
      if (mem_req_o) check("mem_req_addr", {32'd0, mem_req_addr_o}, {32'd0, base});
      check("fill_en_follows_beat", {63'd0, fill_en_o}, {63'd0, drv_valid});
      if (fill_en_o) begin
        f_addr.push_back(fill_addr_o);
        f_data.push_back(fill_data_o);
        f_last.push_back(fill_last_o);
      end
      if (ld_rsp_valid_o) begin
        lds++;
        ld_cyc = cyc;
        check("ld_rsp_data", {32'd0, ld_rsp_data_o}, {32'd0, mem_line[off]});
        check("ld_rsp_rob_idx", {59'd0, ld_rsp_rob_idx_o}, {59'd0, rob});
      end
      if (repair_complete_o) begin
        completes++;
        comp_cyc = cyc;
        done = 1;
      end
      if (accept_now) accepted = 1;
      cyc++;
      if (cyc > 200) begin
        check("complete_within_budget", 64'(completes), 64'd1);
        done = 1;
      end
    end
    mem_req_ready_i = 1'b0;
    if (!hold_req) repair_req_i = 1'b0;

    check("ack_count", 64'(acks), 64'd1);
    check("ack_cycle", 64'(ack_cyc), 64'd0);
    check("complete_count", 64'(completes), 64'd1);
    check("fill_count", 64'(f_addr.size()), 64'(LW));
    for (int i = 0; i < LW; i++) begin
      if (i < f_addr.size()) begin
        exp_word = (is_store && i == off) ? sdata : mem_line[i];
        check($sformatf("fill_addr_%0d", i), {32'd0, f_addr[i]}, {32'd0, base + 32'(4 * i)});
        check($sformatf("fill_data_%0d", i), {32'd0, f_data[i]}, {32'd0, exp_word});
        check($sformatf("fill_last_%0d", i), {63'd0, f_last[i]}, {63'd0, (i == LW - 1)});
      end
    end
    check("ld_rsp_count", 64'(lds), (!is_store && !flushed) ? 64'd1 : 64'd0);
    if (check_lat) begin
      check("complete_latency", 64'(comp_cyc - ack_cyc), is_store ? 64'(2 + LW) : 64'(3 + LW));
      if (!is_store) check("ld_rsp_latency", 64'(ld_cyc - ack_cyc), 64'(2 + LW));
    end
  endtask

  initial begin
    rst_i                = 1'b1;
    flush_i              = 1'b0;
    repair_req_i         = 1'b1;
    repair_req_addr_i    = 32'h0000_1008;
    repair_req_data_i    = '0;
    repair_req_rob_idx_i = '0;
    repair_is_store_i    = 1'b0;
    mem_req_ready_i      = 1'b1;
    mem_rsp_valid_i      = 1'b1;
    mem_rsp_data_i       = 32'h1234_5678;

    // Reset holds every output low, even with a request and beats present.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rst_i           = 1'b0;
    repair_req_i    = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    #2;
    check_all_zero("idle");

    // Load miss, immediate ready, back-to-back beats.
    for (int i = 0; i < LW; i++) mem_line[i] = 32'hA0 + 32'(i);
    run_txn(32'h0000_1008, 32'h0, 5'd5, 1'b0, 0, 0, -1, 1'b0, 1'b1);

    // Store miss merges its data into word 1.
    for (int i = 0; i < LW; i++) mem_line[i] = 32'hB0 + 32'(i);
    run_txn(32'h0000_2004, 32'hDEAD_BEEF, 5'd0, 1'b1, 0, 0, -1, 1'b0, 1'b1);

    // Slow memory: ready after 3 cycles, beats with 2-cycle gaps.
    for (int i = 0; i < LW; i++) mem_line[i] = 32'hC0 + 32'(i);
    run_txn(32'h0000_400C, 32'h0, 5'd17, 1'b0, 3, 2, -1, 1'b0, 1'b0);

    // Flush during WAIT drops the load result but not the fill.
    for (int i = 0; i < LW; i++) mem_line[i] = 32'hD0 + 32'(i);
    run_txn(32'h0000_5000, 32'h0, 5'd9, 1'b0, 0, 1, 1, 1'b0, 1'b0);

    // Reset after two beats abandons the transfer.
    @(negedge clk_i);
    repair_req_i         = 1'b1;
    repair_req_addr_i    = 32'h0000_3008;
    repair_is_store_i    = 1'b0;
    repair_req_rob_idx_i = 5'd3;
    #2;
    check("rst_test_ack", {63'd0, repair_ack_o}, 64'd1);
    @(negedge clk_i);
    repair_req_i    = 1'b0;
    mem_req_ready_i = 1'b1;
    #2;
    check("rst_test_mem_req", {63'd0, mem_req_o}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hE0 + 32'(i);
      #2;
      check("rst_test_fill_before", {63'd0, fill_en_o}, 64'd1);
    end
    @(negedge clk_i);
    mem_rsp_data_i = 32'hE2;
    rst_i          = 1'b1;
    #1;
    check_all_zero("reset_mid_wait");
    @(negedge clk_i);
    rst_i          = 1'b0;
    mem_rsp_data_i = 32'hE3;
    #2;
    check("rst_test_trailing_fill", {62'd0, fill_en_o, mem_req_o}, 64'd0);
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < LW; i++) mem_line[i] = 32'hF0 + 32'(i);
    run_txn(32'h0000_3008, 32'h0, 5'd3, 1'b0, 0, 0, -1, 1'b0, 1'b1);

    // Request held high through a store and then a load.
    for (int i = 0; i < LW; i++) mem_line[i] = 32'h100 + 32'(i);
    run_txn(32'h0000_6008, 32'hCAFE_F00D, 5'd0, 1'b1, 0, 0, -1, 1'b1, 1'b1);
    for (int i = 0; i < LW; i++) mem_line[i] = 32'h200 + 32'(i);
    run_txn(32'h0000_700C, 32'h0, 5'd21, 1'b0, 0, 0, -1, 1'b1, 1'b1);
    @(negedge clk_i);
    repair_req_i = 1'b0;

    // Randomized repairs.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] r_addr, r_data;
      logic [ROB_W-1:0] r_rob;
      logic r_store;
      int r_flush;
      for (int i = 0; i < LW; i++) mem_line[i] = $urandom;
      r_addr  = $urandom & 32'hFFFF_FFFC;
      r_data  = $urandom;
      r_rob   = ROB_W'($urandom_range(31));
      r_store = 1'($urandom_range(1));
      r_flush = ($urandom_range(3) == 0) ? int'($urandom_range(LW - 1)) : -1;
      run_txn(r_addr, r_data, r_rob, r_store, int'($urandom_range(3)),
              int'($urandom_range(2)), r_flush, 1'b0, 1'b0);
    end

    @(negedge clk_i);
    #2;
    check_all_zero("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miss_repair_controller.md
Name: miss_repair_controller

Overview:
- Services repair requests issued by the MSHR, one at a time.
- For each request: fetches the full cache line from next-level memory, streams it into the data cache as word writes, and merges store data on the fly (write-allocate).
- For load misses, returns the requested word with its ROB index to writeback.
- Sits between the MSHR, the L1 data-cache fill port and the memory interface.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, at least 2.
- ROB_IDX_W, $clog2(ROB_ENTRIES), ROB index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  pipeline flush; squashes any pending load response
- repair_req_i  in  1  MSHR has a repair request
- repair_req_addr_i  in  32  miss byte address (word aligned)
- repair_req_data_i  in  32  store data (valid when is_store)
- repair_req_rob_idx_i  in  ROB_IDX_W  ROB index (valid for loads)
- repair_is_store_i  in  1  request is a store
- repair_ack_o  out  1  request accepted this cycle
- repair_complete_o  out  1  one-cycle pulse when the repair finishes
- mem_req_o  out  1  line read request to memory
- mem_req_addr_o  out  32  line-aligned address
- mem_req_ready_i  in  1  memory accepts the request
- mem_rsp_valid_i  in  1  response beat valid
- mem_rsp_data_i  in  32  response beat data, word 0 first, ascending
- fill_en_o  out  1  cache word write
- fill_addr_o  out  32  word address of the write
- fill_data_o  out  32  word data (store-merged)
- fill_last_o  out  1  final word of the line
- ld_rsp_valid_o  out  1  load result valid (one cycle)
- ld_rsp_data_o  out  32  load result word
- ld_rsp_rob_idx_o  out  ROB_IDX_W  ROB index of the result

Behaviour:
- Reset:
  - Asynchronous; forces IDLE.
  - Clears the beat counter, all latched request fields and the drop flag.
  - All outputs are 0 during reset and in IDLE.
  - Reset mid-transfer abandons the transfer. Beats arriving afterwards are ignored because the FSM is no longer in WAIT.
- States: IDLE, MREQ, WAIT, RESP, DONE.
- IDLE:
  - repair_ack_o = repair_req_i (combinational).
  - On ack, latch addr/data/rob_idx/is_store, clear beat_cnt and drop, and go to MREQ.
- MREQ:
  - mem_req_o = 1; mem_req_addr_o = latched address with the low $clog2(LINE_WORDS)+2 bits zeroed.
  - Hold until mem_req_ready_i, then go to WAIT.
- WAIT: on each mem_rsp_valid_i:
  - fill_en_o = 1 in the same cycle (combinational pass-through).
  - fill_addr_o = line_base + 4*beat_cnt.
  - fill_data_o = latched store data if is_store and beat_cnt == word offset, otherwise mem_rsp_data_i.
  - For a load with beat_cnt == word offset, capture mem_rsp_data_i into the result register.
  - beat_cnt increments.
  - fill_last_o = 1 when beat_cnt == LINE_WORDS-1; that beat moves the FSM to RESP for loads, or to DONE for stores.
  - Cycles without mem_rsp_valid_i stall with no fill write.
  - mem_rsp_valid_i outside WAIT is ignored.
- RESP (loads only), one cycle:
  - ld_rsp_valid_o = !drop && !flush_i.
  - Data and rob_idx come from the captured registers.
  - Then go to DONE.
- DONE: repair_complete_o = 1 for exactly one cycle, then IDLE. repair_ack_o is 0 in DONE.
- Flush:
  - flush_i in MREQ, WAIT or RESP during a load repair sets drop. The line fill still completes, the load response is suppressed, and repair_complete_o still pulses so the MSHR releases its repairing state.
  - Flush has no effect on store repairs or in IDLE/DONE.
- Timing:
  - Minimum latency from ack to complete: for a load, ack at cycle 0 and ready at cycle 1 with back-to-back beats gives the last beat at cycle 1+LINE_WORDS, RESP at 2+LINE_WORDS and complete at 3+LINE_WORDS. A store completes one cycle earlier.
  - The earliest next ack is the cycle after DONE.

Decomposition:
- CORE_PKG gains:
  - LINE_WORDS default constant (DCACHE_LINE_WORDS).
  - repair_state_t enum {IDLE, MREQ, WAIT, RESP, DONE}.
- No sub-module. The beat counter and merge mux are inline.

Test Plan:
- Load miss at addr 0x0000_1008, rob_idx 5, LINE_WORDS=4, memory returns 0xA0..0xA3 with ready immediate -> mem_req_addr_o=0x1000; four fills to 0x1000..0x100C with data A0..A3 and fill_last_o on 0x100C; ld_rsp 0xA2 with rob 5 at cycle 6; complete at cycle 7.
- Store miss at 0x2004 with data 0xDEADBEEF, memory returns 0xB0..0xB3 -> fill data B0, DEADBEEF, B2, B3; no ld_rsp; complete one cycle after the last beat.
- mem_req_ready_i held low for 3 cycles, then beats with 2-cycle gaps -> mem_req_o stays high and address stable; fill_en_o only on valid beats; beat order and merge correct.
- flush_i pulsed in WAIT on a load -> all 4 fills still occur; ld_rsp_valid_o never asserts; complete still pulses.
- rst_i asserted mid-WAIT after 2 beats -> outputs 0 immediately; trailing beats produce no fills; a new request after reset is acked in IDLE and completes normally.
- Back-to-back requests, with repair_req_i held high through a store then a load -> second ack is not before the cycle after DONE; exactly one complete per ack.
